// File: rtl/switch_conditioner.sv
// Synchronizes and debounces 16 board switches plus a "next group" button,
// producing a debounced switch vector and a 2-bit group select code.
module switch_conditioner #(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    output logic [15:0] switches,
    output logic [1:0]  mux,
    output logic        sw_changed,
    output logic        mux_changed
);

    localparam int NUM_IN = 17;
    localparam int HIST   = STABLE_SAMPLES - 1;
    localparam int CW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync_a;
    logic [NUM_IN-1:0] sync_b;
    logic [NUM_IN-1:0] hist [HIST];
    logic [NUM_IN-1:0] deb;
    logic [NUM_IN-1:0] deb_next;
    logic [NUM_IN-1:0] all_hi;
    logic [NUM_IN-1:0] all_lo;
    logic [CW-1:0]     tick_cnt;
    logic              tick;
    logic              btn_rise;

    // button rides along as bit 16 so it shares the switch debounce path
    assign raw = {btn_raw, sw_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // hist[0] holds the most recent sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HIST; k++) begin
                hist[k] <= '0;
            end
        end else if (tick) begin
            hist[0] <= sync_b;
            for (int k = 1; k < HIST; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    always_comb begin
        all_hi = sync_b;
        all_lo = ~sync_b;
        for (int k = 0; k < HIST; k++) begin
            all_hi = all_hi & hist[k];
            all_lo = all_lo & ~hist[k];
        end
        deb_next = deb;
        if (tick) begin
            deb_next = (deb | all_hi) & ~all_lo;
        end
        btn_rise = deb_next[16] & ~deb[16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb         <= '0;
            mux         <= '0;
            sw_changed  <= 1'b0;
            mux_changed <= 1'b0;
        end else begin
            deb         <= deb_next;
            sw_changed  <= |(deb_next[15:0] ^ deb[15:0]);
            mux_changed <= btn_rise;
            if (btn_rise) begin
                mux <= mux + 2'd1;
            end
        end
    end

    assign switches = deb[15:0];

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: two instances (sample divider 1 and 4)
// checked every cycle against a run-length debounce model, plus literal pins.
module tb_switch_conditioner;

    localparam int DIV0 = 1;
    localparam int DIV1 = 4;
    localparam int STB  = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic        btn_raw;
    logic [15:0] sw_o  [2];
    logic [1:0]  mux_o [2];
    logic        swc_o [2];
    logic        muxc_o[2];

    int n_pass  = 0;
    int n_total = 0;
    int n_swc   = 0;
    int n_muxc  = 0;
    int n_both  = 0;

    switch_conditioner #(.SAMPLE_DIV(DIV0), .STABLE_SAMPLES(STB)) dut0 (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .switches(sw_o[0]), .mux(mux_o[0]), .sw_changed(swc_o[0]), .mux_changed(muxc_o[0])
    );

    switch_conditioner #(.SAMPLE_DIV(DIV1), .STABLE_SAMPLES(STB)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .switches(sw_o[1]), .mux(mux_o[1]), .sw_changed(swc_o[1]), .mux_changed(muxc_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: two-stage input delay, per-bit run length of equal samples
    logic [16:0] m_d1  [2];
    logic [16:0] m_d2  [2];
    logic [16:0] m_last[2];
    logic [16:0] m_deb [2];
    int          m_run [2][17];
    int          m_tcnt[2];
    logic [1:0]  m_mux [2];
    logic        m_swc [2];
    logic        m_muxc[2];

    function automatic int div_of(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_d1[i]   = '0;
            m_d2[i]   = '0;
            m_last[i] = '0;
            m_deb[i]  = '0;
            m_tcnt[i] = 0;
            m_mux[i]  = '0;
            m_swc[i]  = 1'b0;
            m_muxc[i] = 1'b0;
            for (int b = 0; b < 17; b++) m_run[i][b] = STB - 1;
        end
    endtask

    task automatic model_step();
        logic [16:0] raw;
        logic [16:0] samp;
        logic [16:0] nd;
        logic        tk;
        raw = {btn_raw, sw_raw};
        for (int i = 0; i < 2; i++) begin
            tk = (m_tcnt[i] == div_of(i) - 1);
            m_tcnt[i] = tk ? 0 : m_tcnt[i] + 1;
            samp = m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = raw;
            nd = m_deb[i];
            if (tk) begin
                for (int b = 0; b < 17; b++) begin
                    if (samp[b] == m_last[i][b]) begin
                        if (m_run[i][b] < STB) m_run[i][b] = m_run[i][b] + 1;
                    end else begin
                        m_run[i][b]  = 1;
                        m_last[i][b] = samp[b];
                    end
                    if (m_run[i][b] >= STB && samp[b] != m_deb[i][b]) nd[b] = samp[b];
                end
            end
            m_swc[i]  = (nd[15:0] != m_deb[i][15:0]);
            m_muxc[i] = nd[16] & ~m_deb[i][16];
            if (m_muxc[i]) m_mux[i] = m_mux[i] + 2'd1;
            m_deb[i] = nd;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("switches[%0d]", i), sw_o[i], m_deb[i][15:0]);
                chk($sformatf("mux[%0d]", i), {14'd0, mux_o[i]}, {14'd0, m_mux[i]});
                chk($sformatf("sw_changed[%0d]", i), {15'd0, swc_o[i]}, {15'd0, m_swc[i]});
                chk($sformatf("mux_changed[%0d]", i), {15'd0, muxc_o[i]}, {15'd0, m_muxc[i]});
            end
            if (swc_o[0]) n_swc++;
            if (muxc_o[0]) n_muxc++;
            if (swc_o[0] && muxc_o[0]) n_both++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    int base_swc;
    int base_muxc;
    int base_both;
    int first_e;

    initial begin
        rst_n   = 1'b0;
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b0;
        cyc(3);
        chk("reset_switches", sw_o[0], 16'h0000);
        chk("reset_mux", {14'd0, mux_o[0]}, 16'h0000);
        chk("reset_pulses", {14'd0, swc_o[0], muxc_o[0]}, 16'h0000);
        rst_n = 1'b1;
        cyc(5);
        chk("all_on_edge5", sw_o[0], 16'h0000);
        cyc(1);
        chk("all_on_edge6", sw_o[0], 16'hFFFF);
        chk("all_on_pulse", {15'd0, swc_o[0]}, 16'h0001);
        cyc(10);
        chk("all_on_pulse_count", 16'(n_swc), 16'd1);

        sw_raw = 16'h0000;
        cyc(40);
        base_swc = n_swc;
        sw_raw = 16'h0001;
        cyc(3);
        sw_raw = 16'h0000;
        cyc(20);
        chk("glitch_switches", sw_o[0], 16'h0000);
        chk("glitch_no_pulse", 16'(n_swc - base_swc), 16'd0);

        base_muxc = n_muxc;
        for (int p = 0; p < 4; p++) begin
            btn_raw = 1'b1;
            cyc(20);
            chk($sformatf("press%0d_mux", p), {14'd0, mux_o[0]}, 16'((p + 1) % 4));
            btn_raw = 1'b0;
            cyc(20);
        end
        chk("press_pulse_count", 16'(n_muxc - base_muxc), 16'd4);

        base_swc  = n_swc;
        base_muxc = n_muxc;
        base_both = n_both;
        sw_raw  = 16'hA5A5;
        btn_raw = 1'b1;
        cyc(10);
        chk("joint_switches", sw_o[0], 16'hA5A5);
        chk("joint_mux", {14'd0, mux_o[0]}, 16'h0001);
        chk("joint_both_pulses", 16'(n_both - base_both), 16'd1);
        chk("joint_sw_pulses", 16'(n_swc - base_swc), 16'd1);
        chk("joint_mux_pulses", 16'(n_muxc - base_muxc), 16'd1);
        btn_raw = 1'b0;
        cyc(40);

        sw_raw = 16'h00FF;
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        chk("midreset_switches", sw_o[0], 16'h0000);
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        chk("midreset_edge5", sw_o[0], 16'h0000);
        cyc(1);
        chk("midreset_edge6", sw_o[0], 16'h00FF);
        cyc(40);

        rst_n  = 1'b0;
        sw_raw = 16'h0001;
        cyc(2);
        rst_n   = 1'b1;
        first_e = 0;
        for (int e = 1; e <= 20; e++) begin
            cyc(1);
            if (first_e == 0 && sw_o[1] == 16'h0001) first_e = e;
        end
        chk("div4_latency", 16'(first_e), 16'd16);
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 100000, meaning clock cycles between debounce samples (legal range >= 1).
REQ-002 The block SHALL have parameter STABLE_SAMPLES, default 4, meaning consecutive agreeing samples required to accept a new level (legal range >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 The block SHALL have port sw_raw, input, 16 bits: asynchronous board switch levels.
REQ-006 The block SHALL have port btn_raw, input, 1 bit: asynchronous "next group" push-button, high when pressed.
REQ-007 The block SHALL have port switches, output, 16 bits: debounced switch vector feeding the group selector.
REQ-008 The block SHALL have port mux, output, 2 bits: group select code feeding the group selector.
REQ-009 The block SHALL have port sw_changed, output, 1 bit: one-cycle pulse when any bit of switches changes.
REQ-010 The block SHALL have port mux_changed, output, 1 bit: one-cycle pulse when mux changes.

Function
REQ-011 Each of the 17 raw inputs SHALL pass through a two-flop synchronizer before any other use.
REQ-012 A tick counter SHALL count 0 to SAMPLE_DIV-1 and wrap; tick SHALL be high for exactly the one cycle in which the count equals SAMPLE_DIV-1 (SAMPLE_DIV=1: tick every cycle).
REQ-013 On each tick, each input SHALL shift its synchronized value into a STABLE_SAMPLES-1 deep history register.
REQ-014 On a tick where the synchronized value and all history entries are equal and differ from the debounced level, the debounced level SHALL take that value on the same edge.
REQ-015 Any input excursion shorter than STABLE_SAMPLES consecutive ticks SHALL leave the debounced level unchanged.
REQ-016 With SAMPLE_DIV=1, a raw change set up before edge 1 and held SHALL appear on the output after edge 2+STABLE_SAMPLES, never earlier.
REQ-017 switches SHALL be the registered debounced levels of the 16 switch inputs.
REQ-018 sw_changed SHALL be high in exactly the cycle following the edge on which switches changes, and low otherwise.
REQ-019 On a 0-to-1 transition of the debounced button, mux SHALL increment by one modulo 4 (00, 01, 10, 11, 00).
REQ-020 A held button SHALL produce exactly one increment; release SHALL produce none.
REQ-021 mux_changed SHALL be high in exactly the cycle following each mux increment.
REQ-022 A switch update and a mux increment on the same edge SHALL both take effect, with both pulses in the same cycle.

Reset
REQ-023 While rst_n is low: switches=16'h0000, mux=2'b00, sw_changed=0, mux_changed=0; synchronizers, histories, debounced levels and tick counter SHALL all be 0.
REQ-024 Reset asserted mid-debounce SHALL discard all partial history; after release, inputs already high SHALL undergo the full debounce latency of REQ-016 before appearing.

Verification (SAMPLE_DIV=1, STABLE_SAMPLES=4 unless stated)
REQ-025 Reset with sw_raw=16'hFFFF, then release -> outputs 0 during reset; switches=16'hFFFF after edge 6 post-release; one sw_changed pulse.
REQ-026 sw_raw[0] high for 3 cycles then low -> switches stays 16'h0000; sw_changed never asserted.
REQ-027 btn_raw held 20 cycles, repeated four times -> mux 01, 10, 11, 00; exactly four mux_changed pulses, one per press.
REQ-028 sw_raw=16'hA5A5 and btn_raw high on the same edge, held -> switches=16'hA5A5 and mux=01 on the same edge; sw_changed and mux_changed high together for one cycle.
REQ-029 sw_raw=16'h00FF, rst_n low at edge 4 then released at edge 6 -> switches=16'h0000 during reset; 16'h00FF only after 6 edges post-release.
REQ-030 SAMPLE_DIV=4: sw_raw=16'h0001 held -> switches updates on a tick edge within 2+4*4 edges and not before edge 2+3*4+1.
